// File: rtl/exe_tree_feeder.sv
// Initiator side of the adder-tree start/finish handshake: packs a word-serial
// float32 stream into NI-lane groups, starts the tree and buffers each group sum.
module exe_tree_feeder #(
  parameter int NI      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NI*32-1:0] tree_inputs,
  output logic             tree_start,
  input  logic [31:0]      tree_summation,
  input  logic             tree_finish,
  output logic             sum_valid,
  output logic [31:0]      sum_data,
  output logic             sum_last,
  input  logic             sum_ready,
  output logic             busy,
  output logic             error
);

  localparam int CNT_W  = (NI > 1) ? $clog2(NI) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LAST_LANE  = CNT_W'(NI - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [31:0]         lanes_q [NI];
  logic                grp_last_q;
  logic                in_ready_q;
  logic                tree_start_q;
  logic                sum_valid_q;
  logic [31:0]         sum_data_q;
  logic                sum_last_q;
  logic                busy_q;
  logic                error_q;

  logic                accept_s;
  logic                group_done_s;
  logic                timeout_s;
  logic                enter_fill_s;

  // Handshake decode and next-state selection.
  always_comb begin
    accept_s     = in_valid && in_ready_q;
    group_done_s = accept_s && ((cnt_q == LAST_LANE) || in_last);
    timeout_s    = (wait_cnt_q == WAIT_LIMIT);
    state_d      = state_q;
    case (state_q)
      S_FILL: begin
        if (group_done_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tree_finish) begin
          state_d = S_HOLD;
        end else if (timeout_s) begin
          state_d = S_FILL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (sum_valid_q && sum_ready) begin
          state_d = S_FILL;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
    enter_fill_s = (state_q != S_FILL) && (state_d == S_FILL);
  end

  // FSM state, lane packing, result capture and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      wait_cnt_q   <= '0;
      grp_last_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      tree_start_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= 32'h0000_0000;
      sum_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      for (int k = 0; k < NI; k++) begin
        lanes_q[k] <= 32'h0000_0000;
      end
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == S_FILL);
      busy_q       <= (state_d != S_FILL);
      tree_start_q <= (state_d == S_ISSUE);
      sum_valid_q  <= (state_d == S_HOLD);
      case (state_q)
        S_FILL: begin
          if (accept_s) begin
            lanes_q[cnt_q] <= in_data;
            cnt_q          <= cnt_q + CNT_W'(1);
            grp_last_q     <= in_last;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (tree_finish) begin
            sum_data_q <= tree_summation;
            sum_last_q <= grp_last_q;
          end else if (timeout_s) begin
            error_q <= 1'b1;
          end
        end
        S_HOLD: begin
          sum_data_q <= sum_data_q;
        end
        default: begin
          wait_cnt_q <= '0;
        end
      endcase
      // Every new group starts from +0.0 in all lanes, so short groups pad cleanly.
      if (enter_fill_s) begin
        cnt_q <= '0;
        for (int k = 0; k < NI; k++) begin
          lanes_q[k] <= 32'h0000_0000;
        end
      end
    end
  end

  // Flatten the lane registers onto the operand bus.
  always_comb begin
    tree_inputs = '0;
    for (int k = 0; k < NI; k++) begin
      tree_inputs[k*32 +: 32] = lanes_q[k];
    end
  end

  assign in_ready   = in_ready_q;
  assign tree_start = tree_start_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign sum_last   = sum_last_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_exe_tree_feeder.sv
// Directed bench for exe_tree_feeder with a fixed-latency adder-tree model.
module tb_exe_tree_feeder;

  localparam int NI  = 8;
  localparam int LAT = 6;
  localparam logic [31:0] ONE = 32'h3F80_0000;
  localparam logic [NI*32-1:0] BUS_SEQ  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [NI*32-1:0] BUS_ONE3 = {{5{32'h0000_0000}}, {3{32'h3F80_0000}}};
  localparam logic [NI*32-1:0] BUS_ZERO = {NI{32'h0000_0000}};

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic [NI*32-1:0] tree_inputs;
  logic             tree_start;
  logic [31:0]      tree_summation;
  logic             tree_finish;
  logic             sum_valid;
  logic [31:0]      sum_data;
  logic             sum_last;
  logic             sum_ready;
  logic             busy;
  logic             error;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int resp_wr = 0;
  int resp_rd = 0;
  logic hang = 1'b0;
  logic [31:0] resp_mem [16];

  exe_tree_feeder #(.NI(NI), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .tree_inputs(tree_inputs), .tree_start(tree_start),
    .tree_summation(tree_summation), .tree_finish(tree_finish),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_last(sum_last), .sum_ready(sum_ready),
    .busy(busy), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Tree model: finish pulses LAT cycles after a start, returning the next queued sum.
  initial begin
    int cd;
    cd = 0;
    tree_finish = 1'b0;
    tree_summation = 32'h0000_0000;
    forever begin
      @(posedge clk);
      #1;
      tree_finish = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          tree_finish = 1'b1;
          tree_summation = resp_mem[resp_rd % 16];
          resp_rd = resp_rd + 1;
        end
      end
      if (tree_start === 1'b1 && hang === 1'b0) begin
        cd = LAT;
        start_cnt = start_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [NI*32-1:0] obs, input logic [NI*32-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_resp(input logic [31:0] v);
    resp_mem[resp_wr % 16] = v;
    resp_wr = resp_wr + 1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    chk_b("in_ready_fill", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0000_0000;
  endtask

  task automatic send_ones(input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      send_word(ONE, last && (i == n - 1));
    end
  endtask

  task automatic wait_sum(input string tag);
    int n;
    n = 0;
    while (sum_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk_b(tag, sum_valid, 1'b1);
  endtask

  task automatic ack(input string tag);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk_b({tag, "_released"}, sum_valid, 1'b0);
    chk_b({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0000_0000;
    in_last   = 1'b0;
    sum_ready = 1'b0;
    step();
    step();
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_start", tree_start, 1'b0);
    chk_b("rst_sum_valid", sum_valid, 1'b0);
    chk_w("rst_sum_data", sum_data, 32'h0000_0000);
    chk_b("rst_sum_last", sum_last, 1'b0);
    chk_b("rst_error", error, 1'b0);
    chk_bus("rst_bus", tree_inputs, BUS_ZERO);
    reset = 1'b0;
    step();

    // Full group of words 1..8 with exact start and result latency.
    push_resp(32'h0000_0024);
    for (int i = 1; i <= 8; i++) begin
      send_word(32'(i), (i == 8));
    end
    chk_b("t1_start", tree_start, 1'b1);
    chk_b("t1_in_ready_low", in_ready, 1'b0);
    chk_b("t1_busy", busy, 1'b1);
    chk_bus("t1_bus", tree_inputs, BUS_SEQ);
    step();
    chk_b("t1_start_single", tree_start, 1'b0);
    chk_bus("t1_bus_stable", tree_inputs, BUS_SEQ);
    repeat (5) step();
    chk_b("t1_no_sum_yet", sum_valid, 1'b0);
    step();
    chk_b("t1_sum_valid", sum_valid, 1'b1);
    chk_w("t1_sum_data", sum_data, 32'h0000_0024);
    chk_b("t1_sum_last", sum_last, 1'b1);
    chk_i("t1_start_count", start_cnt, 1);
    ack("t1");
    chk_bus("t1_bus_cleared", tree_inputs, BUS_ZERO);

    // Short vector: three 1.0 words, remaining lanes padded with +0.0.
    push_resp(32'h4040_0000);
    send_ones(3, 1'b1);
    chk_b("t2_start", tree_start, 1'b1);
    chk_bus("t2_bus", tree_inputs, BUS_ONE3);
    wait_sum("t2_sum_valid");
    chk_w("t2_sum_data", sum_data, 32'h4040_0000);
    chk_b("t2_sum_last", sum_last, 1'b1);
    ack("t2");

    // 12-word vector: two sums, only the second closes the vector.
    base = start_cnt;
    push_resp(32'h4100_0000);
    push_resp(32'h4080_0000);
    send_ones(8, 1'b0);
    chk_b("t3_start_a", tree_start, 1'b1);
    wait_sum("t3_sum_valid_a");
    chk_w("t3_sum_data_a", sum_data, 32'h4100_0000);
    chk_b("t3_sum_last_a", sum_last, 1'b0);
    ack("t3a");
    send_ones(4, 1'b1);
    wait_sum("t3_sum_valid_b");
    chk_w("t3_sum_data_b", sum_data, 32'h4080_0000);
    chk_b("t3_sum_last_b", sum_last, 1'b1);
    ack("t3b");
    chk_i("t3_start_count", start_cnt - base, 2);

    // Consumer back-pressure: result held stable, input stalled.
    push_resp(32'h4000_0000);
    send_ones(2, 1'b1);
    wait_sum("t4_sum_valid");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_b("t4_hold_valid", sum_valid, 1'b1);
      chk_w("t4_hold_data", sum_data, 32'h4000_0000);
      chk_b("t4_hold_in_ready", in_ready, 1'b0);
    end
    ack("t4");

    // Tree never finishes: error after 64 WAIT cycles, then normal operation.
    hang = 1'b1;
    send_word(32'h40A0_0000, 1'b1);
    chk_b("t5_start", tree_start, 1'b1);
    repeat (64) step();
    chk_b("t5_err_before", error, 1'b0);
    chk_b("t5_busy_waiting", busy, 1'b1);
    step();
    chk_b("t5_error", error, 1'b1);
    chk_b("t5_back_to_fill", in_ready, 1'b1);
    chk_b("t5_no_sum", sum_valid, 1'b0);
    chk_bus("t5_bus_cleared", tree_inputs, BUS_ZERO);
    hang = 1'b0;
    push_resp(32'h4000_0000);
    send_ones(2, 1'b1);
    wait_sum("t5_next_valid");
    chk_w("t5_next_data", sum_data, 32'h4000_0000);
    chk_b("t5_error_sticky", error, 1'b1);
    ack("t5");

    // Reset in mid-WAIT; the late finish must be ignored.
    push_resp(ONE);
    send_ones(1, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_b("t6_in_ready", in_ready, 1'b1);
    chk_b("t6_busy", busy, 1'b0);
    chk_b("t6_start", tree_start, 1'b0);
    chk_b("t6_sum_valid", sum_valid, 1'b0);
    chk_w("t6_sum_data", sum_data, 32'h0000_0000);
    chk_b("t6_sum_last", sum_last, 1'b0);
    chk_b("t6_error", error, 1'b0);
    chk_bus("t6_bus", tree_inputs, BUS_ZERO);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_b("t6_finish_ignored", sum_valid, 1'b0);
    end
    push_resp(32'h4080_0000);
    send_ones(4, 1'b1);
    wait_sum("t6_next_valid");
    chk_w("t6_next_data", sum_data, 32'h4080_0000);
    chk_b("t6_next_last", sum_last, 1'b1);
    ack("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
